// File: rtl/alu_pkg.sv
// Shared widths, ALU control codes, ID/EX payload and forwarding helpers
// for the ALU issue stage.
package alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX   = 5;
    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] CTRL_MUL = 4'b1100;
    localparam logic [CTRL_W-1:0] CTRL_ILL = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [RIDX-1:0]   rs1;
        logic [RIDX-1:0]   rs2;
        logic [RIDX-1:0]   rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              alusrc;
        logic [CTRL_W-1:0] ctrl;
        logic              regwrite;
        logic              memread;
        logic              illegal;
    } idex_t;

    // Youngest matching producer wins; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic            em_we,
        input logic [RIDX-1:0] em_rd,
        input logic            mw_we,
        input logic [RIDX-1:0] mw_rd,
        input logic [RIDX-1:0] rs
    );
        if (em_we && (em_rd != '0) && (em_rd == rs)) return FWD_EXMEM;
        if (mw_we && (mw_rd != '0) && (mw_rd == rs)) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, forwarding-side and ALU-side signals of the ID/EX boundary.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                flush_i;
    logic                id_valid_i;
    logic [RIDX-1:0]     id_rs1_i;
    logic [RIDX-1:0]     id_rs2_i;
    logic [RIDX-1:0]     id_rd_i;
    logic [XLEN-1:0]     id_rs1_data_i;
    logic [XLEN-1:0]     id_rs2_data_i;
    logic [XLEN-1:0]     id_imm_i;
    logic                id_alusrc_i;
    logic [1:0]          id_aluop_i;
    logic [2:0]          id_funct3_i;
    logic [6:0]          id_funct7_i;
    logic                id_regwrite_i;
    logic                id_memread_i;
    logic                exmem_regwrite_i;
    logic [RIDX-1:0]     exmem_rd_i;
    logic [XLEN-1:0]     exmem_result_i;
    logic                memwb_regwrite_i;
    logic [RIDX-1:0]     memwb_rd_i;
    logic [XLEN-1:0]     memwb_wdata_i;

    logic                ex_valid_o;
    logic [XLEN-1:0]     ex_src1_o;
    logic [XLEN-1:0]     ex_src2_o;
    logic [CTRL_W-1:0]   ex_ctrl_o;
    logic [RIDX-1:0]     ex_rd_o;
    logic                ex_regwrite_o;
    logic                ex_memread_o;
    logic                ex_illegal_o;
    logic                stall_o;

    modport master (
        input  flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alusrc_i,
               id_aluop_i, id_funct3_i, id_funct7_i, id_regwrite_i, id_memread_i,
               exmem_regwrite_i, exmem_rd_i, exmem_result_i,
               memwb_regwrite_i, memwb_rd_i, memwb_wdata_i,
        output ex_valid_o, ex_src1_o, ex_src2_o, ex_ctrl_o, ex_rd_o,
               ex_regwrite_o, ex_memread_o, ex_illegal_o, stall_o
    );

    modport slave (
        output flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alusrc_i,
               id_aluop_i, id_funct3_i, id_funct7_i, id_regwrite_i, id_memread_i,
               exmem_regwrite_i, exmem_rd_i, exmem_result_i,
               memwb_regwrite_i, memwb_rd_i, memwb_wdata_i,
        input  ex_valid_o, ex_src1_o, ex_src2_o, ex_ctrl_o, ex_rd_o,
               ex_regwrite_o, ex_memread_o, ex_illegal_o, stall_o
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct3/funct7 to 4-bit ALU control decode.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0]        i_aluop,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_illegal
);

    logic [CTRL_W-1:0] w_ctrl;

    always_comb begin
        w_ctrl = CTRL_ILL;
        case (aluop_e'(i_aluop))
            ALUOP_MEM:    w_ctrl = CTRL_ADD;
            ALUOP_BRANCH: w_ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (i_funct3)
                    3'b000: begin
                        case (i_funct7)
                            7'b0000000: w_ctrl = CTRL_ADD;
                            7'b0100000: w_ctrl = CTRL_SUB;
                            7'b0000001: w_ctrl = CTRL_MUL;
                            default:    w_ctrl = CTRL_ILL;
                        endcase
                    end
                    3'b111:  w_ctrl = CTRL_AND;
                    3'b110:  w_ctrl = CTRL_OR;
                    3'b010:  w_ctrl = CTRL_SLT;
                    default: w_ctrl = CTRL_ILL;
                endcase
            end
            ALUOP_ITYPE: begin
                case (i_funct3)
                    3'b000:  w_ctrl = CTRL_ADD;
                    3'b111:  w_ctrl = CTRL_AND;
                    3'b110:  w_ctrl = CTRL_OR;
                    3'b010:  w_ctrl = CTRL_SLT;
                    default: w_ctrl = CTRL_ILL;
                endcase
            end
            default: w_ctrl = CTRL_ILL;
        endcase
    end

    // CTRL_ILL is reserved, so it alone marks an undecodable instruction.
    assign o_ctrl    = w_ctrl;
    assign o_illegal = (w_ctrl == CTRL_ILL);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: decode, operand forwarding and load-use stall.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    alu_issue_stage_if.master bus
);

    idex_t             r_idex;
    idex_t             w_idex_nxt;
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_stall;
    logic              w_bubble;
    fwd_sel_e          w_fwd1;
    fwd_sel_e          w_fwd2;
    logic [XLEN-1:0]   w_src1;
    logic [XLEN-1:0]   w_rs2_fwd;

    alu_ctrl_dec u_dec (
        .i_aluop   (bus.id_aluop_i),
        .i_funct3  (bus.id_funct3_i),
        .i_funct7  (bus.id_funct7_i),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    // Load in EX whose destination is read by the instruction in ID.
    assign w_stall = r_idex.valid && r_idex.memread && (r_idex.rd != '0) &&
                     bus.id_valid_i &&
                     ((r_idex.rd == bus.id_rs1_i) || (r_idex.rd == bus.id_rs2_i));

    assign w_bubble = bus.flush_i || w_stall || !bus.id_valid_i;

    always_comb begin
        w_idex_nxt          = '0;
        w_idex_nxt.rs1      = bus.id_rs1_i;
        w_idex_nxt.rs2      = bus.id_rs2_i;
        w_idex_nxt.rd       = bus.id_rd_i;
        w_idex_nxt.rs1_data = bus.id_rs1_data_i;
        w_idex_nxt.rs2_data = bus.id_rs2_data_i;
        w_idex_nxt.imm      = bus.id_imm_i;
        w_idex_nxt.alusrc   = bus.id_alusrc_i;
        w_idex_nxt.ctrl     = w_dec_ctrl;
        if (!w_bubble) begin
            w_idex_nxt.valid    = 1'b1;
            w_idex_nxt.regwrite = bus.id_regwrite_i;
            w_idex_nxt.memread  = bus.id_memread_i;
            w_idex_nxt.illegal  = w_dec_illegal;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_idex <= '0;
        else       r_idex <= w_idex_nxt;
    end

    assign w_fwd1 = fwd_select(bus.exmem_regwrite_i, bus.exmem_rd_i,
                               bus.memwb_regwrite_i, bus.memwb_rd_i, r_idex.rs1);
    assign w_fwd2 = fwd_select(bus.exmem_regwrite_i, bus.exmem_rd_i,
                               bus.memwb_regwrite_i, bus.memwb_rd_i, r_idex.rs2);

    always_comb begin
        case (w_fwd1)
            FWD_EXMEM: w_src1 = bus.exmem_result_i;
            FWD_MEMWB: w_src1 = bus.memwb_wdata_i;
            default:   w_src1 = r_idex.rs1_data;
        endcase
        case (w_fwd2)
            FWD_EXMEM: w_rs2_fwd = bus.exmem_result_i;
            FWD_MEMWB: w_rs2_fwd = bus.memwb_wdata_i;
            default:   w_rs2_fwd = r_idex.rs2_data;
        endcase
    end

    assign bus.ex_valid_o    = r_idex.valid;
    assign bus.ex_src1_o     = w_src1;
    assign bus.ex_src2_o     = r_idex.alusrc ? r_idex.imm : w_rs2_fwd;
    assign bus.ex_ctrl_o     = r_idex.ctrl;
    assign bus.ex_rd_o       = r_idex.rd;
    assign bus.ex_regwrite_o = r_idex.regwrite;
    assign bus.ex_memread_o  = r_idex.memread;
    assign bus.ex_illegal_o  = r_idex.illegal;
    assign bus.stall_o       = w_stall;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: driver queues expectations, monitor checks each cycle.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic        chk_all;
        logic        valid;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        ill;
        logic        stall;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input int id, input string f, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL v%0d.%s got %h exp %h", id, f, got, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            chk(m_e.id, "stall",    32'(bus.stall_o),       32'(m_e.stall));
            chk(m_e.id, "valid",    32'(bus.ex_valid_o),    32'(m_e.valid));
            chk(m_e.id, "regwrite", 32'(bus.ex_regwrite_o), 32'(m_e.rw));
            chk(m_e.id, "memread",  32'(bus.ex_memread_o),  32'(m_e.mr));
            chk(m_e.id, "illegal",  32'(bus.ex_illegal_o),  32'(m_e.ill));
            if (m_e.valid || m_e.chk_all) begin
                chk(m_e.id, "src1", bus.ex_src1_o,        m_e.src1);
                chk(m_e.id, "src2", bus.ex_src2_o,        m_e.src2);
                chk(m_e.id, "ctrl", 32'(bus.ex_ctrl_o),   32'(m_e.ctrl));
                chk(m_e.id, "rd",   32'(bus.ex_rd_o),     32'(m_e.rd));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        bus.flush_i       = 1'b0;
        bus.id_valid_i    = 1'b0;
        bus.id_rs1_i      = '0;
        bus.id_rs2_i      = '0;
        bus.id_rd_i       = '0;
        bus.id_rs1_data_i = '0;
        bus.id_rs2_data_i = '0;
        bus.id_imm_i      = '0;
        bus.id_alusrc_i   = 1'b0;
        bus.id_aluop_i    = 2'b00;
        bus.id_funct3_i   = 3'b000;
        bus.id_funct7_i   = 7'b0000000;
        bus.id_regwrite_i = 1'b0;
        bus.id_memread_i  = 1'b0;
    endtask

    task automatic id_set(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic alusrc, input logic rw, input logic mr);
        bus.id_valid_i    = 1'b1;
        bus.id_aluop_i    = aluop;
        bus.id_funct3_i   = f3;
        bus.id_funct7_i   = f7;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rd_i       = rd;
        bus.id_rs1_data_i = d1;
        bus.id_rs2_data_i = d2;
        bus.id_imm_i      = imm;
        bus.id_alusrc_i   = alusrc;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
    endtask

    task automatic fwd_set(input logic em_we, input logic [4:0] em_rd, input logic [31:0] em_res,
                           input logic mw_we, input logic [4:0] mw_rd, input logic [31:0] mw_d);
        bus.exmem_regwrite_i = em_we;
        bus.exmem_rd_i       = em_rd;
        bus.exmem_result_i   = em_res;
        bus.memwb_regwrite_i = mw_we;
        bus.memwb_rd_i       = mw_rd;
        bus.memwb_wdata_i    = mw_d;
    endtask

    task automatic push_exp(input int id, input logic chk_all, input logic valid,
                            input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] ctrl,
                            input logic [4:0] rd, input logic rw, input logic mr, input logic ill,
                            input logic stall);
        exp_t e;
        e.id = id; e.chk_all = chk_all; e.valid = valid; e.src1 = s1; e.src2 = s2;
        e.ctrl = ctrl; e.rd = rd; e.rw = rw; e.mr = mr; e.ill = ill; e.stall = stall;
        q.push_back(e);
    endtask

    task automatic push_bubble(input int id, input logic stall);
        push_exp(id, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        id_clear();
        fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;

        // Reset held for two edges: everything zero.
        next_cycle();
        push_exp(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        id_set(2'b10, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // add x3 = x1 + x2 issues one cycle later.
        next_cycle();
        id_set(2'b10, 3'b000, 7'b0100000, 5'd4, 5'd5, 5'd6, 32'd9, 32'd4, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(3, 1'b0, 1'b1, 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        next_cycle();
        id_set(2'b10, 3'b000, 7'b0000001, 5'd7, 5'd8, 5'd9, 32'd9, 32'd4, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(4, 1'b0, 1'b1, 32'd9, 32'd4, 4'b0110, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

        next_cycle();
        id_set(2'b10, 3'b011, 7'b0000000, 5'd10, 5'd11, 5'd12, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(5, 1'b0, 1'b1, 32'd9, 32'd4, 4'b1100, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);

        next_cycle();
        id_set(2'b10, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(6, 1'b0, 1'b1, 32'd1, 32'd2, 4'b1111, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);

        next_cycle();
        id_set(2'b10, 3'b000, 7'b0000000, 5'd5, 5'd1, 5'd7, 32'h0BAD, 32'h11, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(7, 1'b0, 1'b1, 32'd3, 32'd4, 4'b0010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Both producers target x5: EX/MEM must win.
        next_cycle();
        fwd_set(1'b1, 5'd5, 32'h20, 1'b1, 5'd5, 32'h10);
        id_set(2'b00, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'd8, 1'b1, 1'b1, 1'b1);
        push_exp(8, 1'b0, 1'b1, 32'h20, 32'h11, 4'b0010, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // lw x6 in EX, ID reads x6 through rs2: stall.
        next_cycle();
        fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_set(2'b10, 3'b000, 7'b0000000, 5'd2, 5'd6, 5'd8, 32'd5, 32'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        push_exp(9, 1'b0, 1'b1, 32'h100, 32'd8, 4'b0010, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);

        next_cycle();
        push_bubble(10, 1'b0);

        // Load data now arrives via MEM/WB on rs2.
        next_cycle();
        fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h77);
        id_set(2'b11, 3'b000, 7'b0000000, 5'd0, 5'd3, 5'd9, 32'd0, 32'd3, 32'hFFFF_FFF4, 1'b1, 1'b1, 1'b0);
        push_exp(11, 1'b0, 1'b1, 32'd5, 32'h77, 4'b0010, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);

        // x0 is never forwarded; imm path ignores forwarding. Flush the ID instruction.
        next_cycle();
        fwd_set(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        id_set(2'b10, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd10, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0);
        bus.flush_i = 1'b1;
        push_exp(12, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF4, 4'b0010, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);

        next_cycle();
        bus.flush_i = 1'b0;
        fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_set(2'b11, 3'b110, 7'b0000000, 5'd3, 5'd0, 5'd11, 32'hF0, 32'h0, 32'h0F, 1'b1, 1'b1, 1'b0);
        push_bubble(13, 1'b0);

        next_cycle();
        id_set(2'b00, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd12, 32'h200, 32'h0, 32'd4, 1'b1, 1'b1, 1'b1);
        push_exp(14, 1'b0, 1'b1, 32'hF0, 32'h0F, 4'b0001, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load-use and flush together: stall still asserts, bubble follows.
        next_cycle();
        id_set(2'b01, 3'b000, 7'b0000000, 5'd12, 5'd3, 5'd0, 32'd8, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.flush_i = 1'b1;
        push_exp(15, 1'b0, 1'b1, 32'h200, 32'd4, 4'b0010, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);

        next_cycle();
        bus.flush_i = 1'b0;
        id_set(2'b10, 3'b010, 7'b0000000, 5'd12, 5'd3, 5'd13, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1, 1'b0);
        push_bubble(16, 1'b0);

        // MEM/WB-only match on rs2; id_valid=0 must yield a bubble.
        next_cycle();
        fwd_set(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33);
        id_set(2'b10, 3'b111, 7'b0000000, 5'd1, 5'd2, 5'd14, 32'hFF, 32'h0F, 32'h0, 1'b0, 1'b1, 1'b1);
        bus.id_valid_i = 1'b0;
        push_exp(17, 1'b0, 1'b1, 32'd1, 32'h33, 4'b0111, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);

        next_cycle();
        fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_set(2'b00, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd15, 32'h300, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        push_bubble(18, 1'b0);

        // Reset during a stall clears the stalling load.
        next_cycle();
        id_set(2'b01, 3'b000, 7'b0000000, 5'd15, 5'd0, 5'd0, 32'd8, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        push_exp(19, 1'b0, 1'b1, 32'h300, 32'h0, 4'b0010, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1);

        next_cycle();
        rst = 1'b0;
        push_exp(20, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        next_cycle();
        id_clear();
        push_exp(21, 1'b0, 1'b1, 32'd8, 32'd3, 4'b0110, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        next_cycle();
        push_bubble(22, 1'b0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
